prog_loader: RTL

//  Writer side of the processor's instruction/data memories: receives a framed

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_if.sv | 29 ++
 rtl/prog_loader_word_assembler.sv | 48 ++++
 rtl/prog_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: word width, sync marker,
// target codes and the loader state encoding.
package prog_loader_pkg;

  localparam int WORD_W = 16;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] TGT_INSTR    = 8'h00;
  localparam logic [7:0] TGT_DATA     = 8'h01;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_TGT,
    ST_AH,
    ST_AL,
    ST_CH,
    ST_CL,
    ST_DH,
    ST_DL,
    ST_CSUM,
    ST_DONE
  } state_t;

  function automatic logic tgt_valid(input logic [7:0] code);
    return (code == TGT_INSTR) || (code == TGT_DATA);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, memory write port and processor control of the loader.
// master = host/processor side, slave = loader.
interface prog_loader_if #(
  parameter int ADDR_W = 16
);
  import prog_loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              proc_hold;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_byte,
    input  in_ready, wr_en, wr_sel, wr_addr, wr_data, proc_hold, done, err
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, wr_en, wr_sel, wr_addr, wr_data, proc_hold, done, err
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Pairs hi/lo data bytes into 16-bit words and issues the registered memory
// write strobe; owns the running word address and its modulo wrap.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              hi_take,
  input  logic              lo_take,
  input  logic              sel,
  input  logic [7:0]        data_byte,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data
);

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        hi_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      hi_q    <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= lo_take;
      if (addr_load) addr_q <= load_addr;
      if (hi_take)   hi_q   <= data_byte;
      if (lo_take) begin
        wr_sel  <= sel;
        wr_addr <= addr_q;
        wr_data <= {hi_q, data_byte};
        addr_q  <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for instruction/data memories; holds the processor
// in reset until a terminate frame. Define LOADER_CHECKSUM_EN for the CSUM byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         ADDR_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t DATA_END = ST_CSUM;
  localparam state_t ZERO_END = ST_CSUM;
`else
  localparam state_t DATA_END = ST_HUNT;
  localparam state_t ZERO_END = ST_DONE;
`endif

  state_t      state_q, state_d;
  logic        in_ready_q, done_q, err_q, sel_q;
  logic [7:0]  addr_hi_q;
  logic [15:0] cnt_q;
  logic        xfer, hi_take, lo_take, addr_load, err_set;
  logic [7:0]  b;

  assign b    = bus.in_byte;
  assign xfer = bus.in_valid & in_ready_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       zero_q;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    hi_take   = 1'b0;
    lo_take   = 1'b0;
    addr_load = 1'b0;
    err_set   = 1'b0;
    if (xfer) begin
      unique case (state_q)
        ST_HUNT: if (b == SYNC_BYTE) state_d = ST_TGT;
        ST_TGT: begin
          if (tgt_valid(b)) state_d = ST_AH;
          else begin
            err_set = 1'b1;
            state_d = ST_HUNT;
          end
        end
        ST_AH: state_d = ST_AL;
        ST_AL: begin
          addr_load = 1'b1;
          state_d   = ST_CH;
        end
        ST_CH: state_d = ST_CL;
        ST_CL: state_d = ({cnt_q[15:8], b} == 16'd0) ? ZERO_END : ST_DH;
        ST_DH: begin
          hi_take = 1'b1;
          state_d = ST_DL;
        end
        ST_DL: begin
          lo_take = 1'b1;
          state_d = (cnt_q == 16'd1) ? DATA_END : ST_DH;
        end
        ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (b != csum_q) begin
            err_set = 1'b1;
            state_d = ST_HUNT;
          end else begin
            state_d = zero_q ? ST_DONE : ST_HUNT;
          end
`else
          state_d = ST_HUNT;
`endif
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_HUNT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= 1'b0;
      addr_hi_q  <= '0;
      cnt_q      <= '0;
    end else begin
      in_ready_q <= (state_d != ST_DONE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= err_q | err_set;
      if (xfer) begin
        unique case (state_q)
          ST_TGT:  sel_q       <= (b == TGT_DATA);
          ST_AH:   addr_hi_q   <= b;
          ST_CH:   cnt_q[15:8] <= b;
          ST_CL:   cnt_q[7:0]  <= b;
          ST_DL:   cnt_q       <= cnt_q - 16'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR from TGT through the last data byte; zero_q marks a count-0 frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
      zero_q <= 1'b0;
    end else if (xfer) begin
      unique case (state_q)
        ST_TGT:                               csum_q <= b;
        ST_AH, ST_AL, ST_CH, ST_DH, ST_DL:    csum_q <= csum_q ^ b;
        ST_CL: begin
          csum_q <= csum_q ^ b;
          zero_q <= ({cnt_q[15:8], b} == 16'd0);
        end
        default: ;
      endcase
    end
  end
`endif

  prog_loader_word_assembler #(
    .ADDR_W (ADDR_W)
  ) u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .addr_load (addr_load),
    .load_addr (ADDR_W'({addr_hi_q, b})),
    .hi_take   (hi_take),
    .lo_take   (lo_take),
    .sel       (sel_q),
    .data_byte (b),
    .wr_en     (bus.wr_en),
    .wr_sel    (bus.wr_sel),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.done      = done_q;
  assign bus.proc_hold = ~done_q;
  assign bus.err       = err_q;

endmodule
